// File: rtl/user_wb_gpio_responder.sv
// Wishbone classic register window onto the 38 user IO pads (out, oeb, synced in).
// Optional rising-edge GPIO interrupt on io_in[31:0] when USER_WB_GPIO_IRQ_EN is defined.
module user_wb_gpio_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
    parameter int          SYNC_STAGES = 2,
    parameter logic [37:0] OEB_RESET   = 38'h3F_FFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  user_irq
);

    logic [37:0] sync_q [SYNC_STAGES];
    logic [37:0] pads;
    logic        hit;
    logic        req;
    logic        wr;
    logic [5:0]  word;
    logic [31:0] rdata;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return r;
    endfunction

    assign pads = sync_q[SYNC_STAGES-1];
    assign hit  = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    // The !ack term forces the idle cycle between consecutive acks.
    assign req  = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr   = req & wbs_we_i;
    assign word = wbs_adr_i[7:2];

`ifdef USER_WB_GPIO_IRQ_EN
    logic [31:0] irq_mask;
    logic [31:0] irq_stat;
    logic [31:0] in_prev;
    logic        irq_q;
    logic [31:0] rise;
    logic [31:0] clr;

    assign rise = pads[31:0] & ~in_prev;
    assign clr  = (wr && word == 6'd7) ? byte_merge(32'h0, wbs_dat_i, wbs_sel_i) : 32'h0;

    // Hardware set is OR-ed after the W1C clear so a coincident edge survives.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_mask <= '0;
            irq_stat <= '0;
            in_prev  <= '0;
            irq_q    <= 1'b0;
        end else begin
            in_prev  <= pads[31:0];
            irq_stat <= (irq_stat & ~clr) | rise;
            irq_q    <= |(irq_stat & irq_mask);
            if (wr && word == 6'd6) irq_mask <= byte_merge(irq_mask, wbs_dat_i, wbs_sel_i);
        end
    end

    assign user_irq = {2'b00, irq_q};
`else
    assign user_irq = 3'b000;
`endif

    always_comb begin
        rdata = 32'h0;
        case (word)
            6'd0: rdata = io_out[31:0];
            6'd1: rdata = {26'h0, io_out[37:32]};
            6'd2: rdata = io_oeb[31:0];
            6'd3: rdata = {26'h0, io_oeb[37:32]};
            6'd4: rdata = pads[31:0];
            6'd5: rdata = {26'h0, pads[37:32]};
`ifdef USER_WB_GPIO_IRQ_EN
            6'd6: rdata = irq_mask;
            6'd7: rdata = irq_stat;
`endif
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            io_out    <= '0;
            io_oeb    <= OEB_RESET;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
            if (wr) begin
                case (word)
                    6'd0: io_out[31:0]  <= byte_merge(io_out[31:0], wbs_dat_i, wbs_sel_i);
                    6'd1: if (wbs_sel_i[0]) io_out[37:32] <= wbs_dat_i[5:0];
                    6'd2: io_oeb[31:0]  <= byte_merge(io_oeb[31:0], wbs_dat_i, wbs_sel_i);
                    6'd3: if (wbs_sel_i[0]) io_oeb[37:32] <= wbs_dat_i[5:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
